// File: rtl/nano_pkg.sv
// Shared widths and FSM encoding for the nano memory arbiter.
package nano_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);
  always_comb begin
    winner = (req == 2'b11) ? ~last : req[1];
  end
endmodule

// File: rtl/nano_mem_arbiter.sv
// Single-port memory shared by a CPU (0) and a loader (1); IDLE->ACCESS->RESP per transfer.
module nano_mem_arbiter
  import nano_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t                   r_state;
  logic                     r_last;
  logic                     r_owner;
  logic                     r_we;
  logic [ADDR_W-1:0]        r_addr;
  logic [DATA_W-1:0]        r_wdata;
  logic [1:0][DATA_W-1:0]   r_rdata;

  logic [1:0]               w_req;
  logic                     w_win;

  assign w_req = {req1, req0};

  rr_arbiter2 u_rr (
    .req    (w_req),
    .last   (r_last),
    .winner (w_win)
  );

  // Reset drops any in-flight transfer; r_last=1 hands the first tie to the CPU.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_owner <= w_win;
            r_we    <= w_win ? we1    : we0;
            r_addr  <= w_win ? addr1  : addr0;
            r_wdata <= w_win ? wdata1 : wdata0;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!r_we) r_rdata[r_owner] <= mem_rdata;
          r_state <= RESP;
        end
        RESP: begin
          r_last  <= r_owner;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory bus is quiet outside ACCESS so stale addresses never leak out.
  assign mem_ce    = (r_state == ACCESS);
  assign mem_we    = mem_ce & r_we;
  assign mem_addr  = mem_ce ? r_addr  : '0;
  assign mem_wdata = mem_ce ? r_wdata : '0;

  assign ack0   = (r_state == RESP) & ~r_owner;
  assign ack1   = (r_state == RESP) &  r_owner;
  assign rdata0 = r_rdata[0];
  assign rdata1 = r_rdata[1];
endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level model.
module tb_nano_mem_arbiter;
  logic        ck = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, mem_ce, mem_we;
  logic [15:0] rdata0, rdata1;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:255];
  logic [15:0] refmem [0:255];
  logic [15:0] exp_rd0, exp_rd1;
  int          m_last;

  always #5 ck = ~ck;

  nano_mem_arbiter dut (
    .ck(ck), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // External memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge ck) if (mem_ce && mem_we) mem[mem_addr] <= mem_wdata;

  always @(negedge ck) begin
    if (rst) begin
      n_tests++;
      if (ack0 && ack1) begin
        n_fail++;
        $display("FAIL ack_exclusive: ack0=%0b ack1=%0b required not both 1", ack0, ack1);
      end
    end
  end

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic do_reset();
    @(negedge ck);
    rst = 0;
    idle_inputs();
    repeat (2) @(negedge ck);
    rst = 1;
    exp_rd0 = 0; exp_rd1 = 0; m_last = 1;
  endtask

  // Returns who=-1 if no ack arrives within the budget.
  task automatic wait_ack(output int who, output int cyc);
    who = -1; cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge ck);
      if (ack0) begin who = 0; cyc = i; break; end
      if (ack1) begin who = 1; cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge ck);
    rst = 0;
    idle_inputs();
    #1;
    n_tests++;
    if ({ack0, ack1, mem_ce, mem_we} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {ack0, ack1, mem_ce, mem_we});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, rdata0, rdata1} !== 56'h0) begin
      n_fail++; $display("FAIL reset_data: addr=%h wdata=%h rd0=%h rd1=%h required all 0",
                         mem_addr, mem_wdata, rdata0, rdata1);
    end
    @(negedge ck);
    rst = 1;
    exp_rd0 = 0; exp_rd1 = 0; m_last = 1;
    repeat (2) @(negedge ck);
    n_tests++;
    if (mem_ce !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req: mem_ce=%b required 0", mem_ce);
    end
  endtask

  task automatic test_cpu_read();
    mem[30] = 16'h000A;
    req0 = 1; we0 = 0; addr0 = 8'd30;
    @(negedge ck);
    n_tests++;
    if ({mem_ce, mem_we, mem_addr} !== {1'b1, 1'b0, 8'd30}) begin
      n_fail++; $display("FAIL read_access: ce=%b we=%b addr=%0d required 1 0 30", mem_ce, mem_we, mem_addr);
    end
    @(negedge ck);
    n_tests++;
    if ({ack0, ack1, mem_ce, rdata0} !== {3'b100, 16'h000A}) begin
      n_fail++; $display("FAIL read_ack: ack0=%b ack1=%b ce=%b rdata0=%h required 1 0 0 000a",
                         ack0, ack1, mem_ce, rdata0);
    end
    exp_rd0 = 16'h000A; m_last = 0;
    req0 = 0;
    @(negedge ck);
    n_tests++;
    if (ack0 !== 1'b0) begin
      n_fail++; $display("FAIL read_ack_pulse: ack0=%b required 0", ack0);
    end
  endtask

  task automatic test_loader_write();
    req1 = 1; we1 = 1; addr1 = 8'd16; wdata1 = 16'h0037;
    @(negedge ck);
    n_tests++;
    if ({mem_ce, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'd16, 16'h0037}) begin
      n_fail++; $display("FAIL write_access: ce=%b we=%b addr=%0d wdata=%h required 1 1 16 0037",
                         mem_ce, mem_we, mem_addr, mem_wdata);
    end
    @(negedge ck);
    n_tests++;
    if ({ack1, ack0, mem_we} !== 3'b100 || mem[16] !== 16'h0037 || rdata1 !== exp_rd1 || rdata0 !== exp_rd0) begin
      n_fail++; $display("FAIL write_ack: ack1=%b ack0=%b we=%b mem16=%h rd1=%h rd0=%h required 1 0 0 0037 %h %h",
                         ack1, ack0, mem_we, mem[16], rdata1, rdata0, exp_rd1, exp_rd0);
    end
    m_last = 1;
    req1 = 0; we1 = 0;
    @(negedge ck);
  endtask

  task automatic test_tie();
    int w1, c1, w2, c2;
    do_reset();
    mem[1] = 16'h1111; mem[2] = 16'h2222;
    req0 = 1; addr0 = 8'd1; we0 = 0;
    req1 = 1; addr1 = 8'd2; we1 = 0;
    wait_ack(w1, c1);
    req0 = 0;
    wait_ack(w2, c2);
    req1 = 0;
    n_tests++;
    if (w1 !== 0 || w2 !== 1) begin
      n_fail++; $display("FAIL tie_order: got %0d,%0d required 0,1", w1, w2);
    end
    n_tests++;
    if (c2 !== 3 || rdata0 !== 16'h1111 || rdata1 !== 16'h2222) begin
      n_fail++; $display("FAIL tie_spacing: gap=%0d rd0=%h rd1=%h required 3 1111 2222", c2, rdata0, rdata1);
    end
    exp_rd0 = 16'h1111; exp_rd1 = 16'h2222; m_last = 1;
    @(negedge ck);
  endtask

  task automatic test_contention();
    int order [$];
    req0 = 1; we0 = 0; addr0 = 8'd1;
    req1 = 1; we1 = 0; addr1 = 8'd2;
    for (int i = 0; i < 40 && order.size() < 6; i++) begin
      @(negedge ck);
      if (ack0) order.push_back(0);
      if (ack1) order.push_back(1);
    end
    req0 = 0; req1 = 0;
    n_tests++;
    if (order.size() != 6) begin
      n_fail++; $display("FAIL contention_count: got %0d grants required 6", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      n_tests++;
      if (order[i] != (i % 2)) begin
        n_fail++; $display("FAIL contention_order: grant %0d to %0d required %0d", i, order[i], i % 2);
      end
    end
    m_last = 1;
    @(negedge ck);
    @(negedge ck);
  endtask

  task automatic test_reset_mid();
    int seen;
    mem[5] = 16'h1111;
    req1 = 1; we1 = 1; addr1 = 8'd5; wdata1 = 16'h0055;
    @(negedge ck);
    n_tests++;
    if (mem_ce !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_setup: ce=%b we=%b required 1 1", mem_ce, mem_we);
    end
    rst = 0;
    #1;
    n_tests++;
    if ({ack0, ack1, mem_ce, mem_we, mem_addr, mem_wdata, rdata0, rdata1} !== 60'h0) begin
      n_fail++; $display("FAIL rst_mid_outputs: ack=%b%b ce=%b we=%b addr=%h wd=%h rd0=%h rd1=%h required all 0",
                         ack0, ack1, mem_ce, mem_we, mem_addr, mem_wdata, rdata0, rdata1);
    end
    idle_inputs();
    @(negedge ck);
    rst = 1;
    exp_rd0 = 0; exp_rd1 = 0; m_last = 1;
    seen = 0;
    repeat (6) begin
      @(negedge ck);
      if (ack0 || ack1 || mem_ce) seen++;
    end
    n_tests++;
    if (seen != 0 || mem[5] !== 16'h1111) begin
      n_fail++; $display("FAIL rst_mid_after: activity=%0d mem5=%h required 0 1111", seen, mem[5]);
    end
  endtask

  task automatic test_drop_req();
    int cnt;
    mem[7] = 16'hBEEF;
    req0 = 1; we0 = 0; addr0 = 8'd7;
    @(negedge ck);
    req0 = 0;
    cnt = 0;
    repeat (4) begin
      @(negedge ck);
      if (ack0) cnt++;
    end
    n_tests++;
    if (cnt != 1 || rdata0 !== 16'hBEEF) begin
      n_fail++; $display("FAIL drop_req: ack0 pulses=%0d rdata0=%h required 1 beef", cnt, rdata0);
    end
    exp_rd0 = 16'hBEEF; m_last = 0;
  endtask

  task automatic test_random();
    bit p0, p1;
    int who, cyc, expw;
    do_reset();
    for (int a = 0; a < 256; a++) begin
      mem[a] = 16'($urandom);
      refmem[a] = mem[a];
    end
    p0 = 0; p1 = 0;
    for (int t = 0; t < 60; t++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; req0 = 1; we0 = 1'($urandom); addr0 = 8'($urandom_range(0, 15)); wdata0 = 16'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; req1 = 1; we1 = 1'($urandom); addr1 = 8'($urandom_range(0, 15)); wdata1 = 16'($urandom);
      end
      if (!p0 && !p1) begin
        p0 = 1; req0 = 1; we0 = 0; addr0 = 8'($urandom_range(0, 15));
      end
      expw = (p0 && p1) ? (m_last == 1 ? 0 : 1) : (p0 ? 0 : 1);
      wait_ack(who, cyc);
      n_tests++;
      if (who != expw) begin
        n_fail++; $display("FAIL rand_winner: txn %0d granted %0d required %0d", t, who, expw);
      end
      if (expw == 0) begin
        if (we0) refmem[addr0] = wdata0; else exp_rd0 = refmem[addr0];
        p0 = 0; req0 = 0;
      end else begin
        if (we1) refmem[addr1] = wdata1; else exp_rd1 = refmem[addr1];
        p1 = 0; req1 = 0;
      end
      m_last = expw;
      n_tests++;
      if (rdata0 !== exp_rd0 || rdata1 !== exp_rd1) begin
        n_fail++; $display("FAIL rand_rdata: txn %0d rd0=%h rd1=%h required %h %h", t, rdata0, rdata1, exp_rd0, exp_rd1);
      end
      @(negedge ck);
      n_tests++;
      if (ack0 || ack1) begin
        n_fail++; $display("FAIL rand_ack_pulse: txn %0d ack0=%b ack1=%b required 0 0", t, ack0, ack1);
      end
      if (who < 0) break;
    end
    idle_inputs();
    repeat (4) @(negedge ck);
    for (int a = 0; a < 16; a++) begin
      n_tests++;
      if (mem[a] !== refmem[a]) begin
        n_fail++; $display("FAIL rand_mem: addr %0d holds %h required %h", a, mem[a], refmem[a]);
      end
    end
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    exp_rd0 = 0; exp_rd1 = 0; m_last = 1;
    for (int a = 0; a < 256; a++) mem[a] = 16'h0;
    test_reset();
    test_cpu_read();
    test_loader_write();
    test_tie();
    test_contention();
    test_reset_mid();
    test_drop_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
